fetch_stage: RTL

//  Instruction-fetch stage of the LEGv8 core. Holds the PC, issues one word

---
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage.sv | 109 ++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and instruction memory (slave).
interface fetch_stage_if #(
    parameter int N = 64
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic [31:0]  imem_rdata;
    logic         imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC, single outstanding fetch, IF/ID buffer with branch flush.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_stage_if.master imem,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic [31:0]  instr,
    output logic [10:0]  instr_op,
    output logic [N-1:0] instr_pc,
    output logic         instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    localparam logic [0:0]   ST_READY   = 1'b0;
    localparam logic [0:0]   ST_WAIT    = 1'b1;
    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

    logic [0:0]   state;
    logic [N-1:0] pc;
    logic         kill;
    logic         issue;
    logic         consume;
    logic         capture;

    // A fetch is only issued when the buffer will be free by the time the word returns.
    always_comb begin
        issue   = reset_n && (state == ST_READY) && !redirect && (!instr_valid || !stall);
        consume = instr_valid && !stall;
        capture = (state == ST_WAIT) && imem.imem_rvalid && !redirect && !kill;
    end

    assign imem.imem_req  = issue;
    assign imem.imem_addr = pc;
    assign instr_op       = instr[31:21];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_READY;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= redirect_pc & ALIGN_MASK;
            instr_valid <= 1'b0;
            if (state == ST_WAIT) begin
                if (imem.imem_rvalid) begin
                    state <= ST_READY;
                    kill  <= 1'b0;
                end else begin
                    kill  <= 1'b1;
                end
            end
        end else begin
            if (consume) begin
                instr_valid <= 1'b0;
            end
            case (state)
                ST_READY: begin
                    if (issue) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A killed fetch still has to drain before the next one may issue.
                    if (imem.imem_rvalid) begin
                        state <= ST_READY;
                        kill  <= 1'b0;
                    end
                    if (capture) begin
                        instr       <= imem.imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + N'(4);
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (capture) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (instr_valid && stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
